// File: rtl/qam_mapper.sv
// Serial-bit to Gray-coded QPSK / 16-QAM I/Q mapper with a one-cycle symbol strobe.
// Optional symbol counter output sym_cnt is built when QAM_SYM_CNT_EN is defined.
module qam_mapper #(
    parameter int AMP_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    input  logic                    flush,
    output logic signed [AMP_W-1:0] I,
    output logic signed [AMP_W-1:0] Q,
    output logic                    sym_valid,
    output logic                    busy
`ifdef QAM_SYM_CNT_EN
    ,
    output logic [CNT_W-1:0]        sym_cnt
`endif
);

    typedef enum logic {
        MODE_QPSK  = 1'b0,
        MODE_QAM16 = 1'b1
    } mode_e;

    localparam logic signed [AMP_W-1:0] LVL_P3 = AMP_W'(3);
    localparam logic signed [AMP_W-1:0] LVL_P1 = AMP_W'(1);
    localparam logic signed [AMP_W-1:0] LVL_M1 = AMP_W'(-1);
    localparam logic signed [AMP_W-1:0] LVL_M3 = AMP_W'(-3);

    // Gray pair to level: 00->-3, 01->-1, 11->+1, 10->+3
    function automatic logic signed [AMP_W-1:0] gray_lvl(input logic [1:0] pair);
        logic signed [AMP_W-1:0] lvl;
        case (pair)
            2'b00:   lvl = LVL_M3;
            2'b01:   lvl = LVL_M1;
            2'b11:   lvl = LVL_P1;
            default: lvl = LVL_P3;
        endcase
        return lvl;
    endfunction

    logic [1:0]              cnt_q, cnt_d;
    logic [3:0]              sr_q, sr_d;
    mode_e                   mode_q, mode_d;
    logic                    pend_q, pend_d;
    logic [3:0]              pend_bits_q, pend_bits_d;
    mode_e                   pend_mode_q, pend_mode_d;
    logic signed [AMP_W-1:0] i_q, i_d, q_q, q_d;
    logic                    sym_valid_q, sym_valid_d;
    logic                    busy_q, busy_d;

    mode_e                   eff_mode;
    logic [3:0]              sr_next;
    logic [2:0]              cnt_inc;
    logic [2:0]              need_n;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        mode_d      = mode_q;
        pend_d      = 1'b0;
        pend_bits_d = pend_bits_q;
        pend_mode_d = pend_mode_q;
        i_d         = i_q;
        q_d         = q_q;
        sym_valid_d = 1'b0;
        eff_mode    = (cnt_q == 2'd0) ? mode_e'(mode) : mode_q;
        sr_next     = {sr_q[2:0], bit_in};
        cnt_inc     = {1'b0, cnt_q} + 3'd1;
        need_n      = (eff_mode == MODE_QAM16) ? 3'd4 : 3'd2;

        if (!en) begin
            cnt_d = 2'd0;
            i_d   = '0;
            q_d   = '0;
        end else if (flush) begin
            cnt_d = 2'd0;
        end else begin
            // A symbol completed on the previous edge is presented now.
            if (pend_q) begin
                if (pend_mode_q == MODE_QAM16) begin
                    i_d = gray_lvl(pend_bits_q[3:2]);
                    q_d = gray_lvl(pend_bits_q[1:0]);
                end else begin
                    i_d = pend_bits_q[0] ? LVL_P3 : LVL_M3;
                    q_d = pend_bits_q[1] ? LVL_M3 : LVL_P3;
                end
                sym_valid_d = 1'b1;
            end
            if (bit_valid) begin
                mode_d = eff_mode;
                sr_d   = sr_next;
                if (cnt_inc == need_n) begin
                    cnt_d       = 2'd0;
                    pend_d      = 1'b1;
                    pend_bits_d = sr_next;
                    pend_mode_d = eff_mode;
                end else begin
                    cnt_d = cnt_inc[1:0];
                end
            end
        end
        busy_d = (cnt_d != 2'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= 2'd0;
            sr_q        <= 4'd0;
            mode_q      <= MODE_QPSK;
            pend_q      <= 1'b0;
            pend_bits_q <= 4'd0;
            pend_mode_q <= MODE_QPSK;
            i_q         <= '0;
            q_q         <= '0;
            sym_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            mode_q      <= mode_d;
            pend_q      <= pend_d;
            pend_bits_q <= pend_bits_d;
            pend_mode_q <= pend_mode_d;
            i_q         <= i_d;
            q_q         <= q_d;
            sym_valid_q <= sym_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign I         = i_q;
    assign Q         = q_q;
    assign sym_valid = sym_valid_q;
    assign busy      = busy_q;

`ifdef QAM_SYM_CNT_EN
    logic [CNT_W-1:0] sym_cnt_q;

    // Cleared only by reset; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_cnt_q <= '0;
        end else if (sym_valid_d) begin
            sym_cnt_q <= sym_cnt_q + 1'b1;
        end
    end

    assign sym_cnt = sym_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
- Parametrised serial-to-symbol constellation mapper; next generation of the fixed QPSK mapper.
- Collects serial bits strobed by a qualifier, not by internally generated sample clocks.
- Maps to Gray-coded QPSK or 16-QAM I/Q levels, selectable at run time.
- Sits between the serial bit source (e.g. conv_S stream) and the I/Q modulator/DAC path; emits a one-cycle symbol-valid strobe.

Parameters:
- AMP_W, 4, signed width of I and Q outputs; legal range AMP_W >= 3; levels sign-extended to AMP_W.
- CNT_W, 16, width of the symbol counter; used only when QAM_SYM_CNT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  mapper enable; low = idle, drop partial symbol.
- mode  in  1  0 = QPSK (2 bits/symbol), 1 = 16-QAM (4 bits/symbol).
- bit_in  in  1  serial data bit (conv_S).
- bit_valid  in  1  bit_in is sampled on a clk edge where bit_valid=1 and en=1.
- flush  in  1  synchronous drop of any partial symbol.
- I  out  AMP_W  signed in-phase level.
- Q  out  AMP_W  signed quadrature level.
- sym_valid  out  1  one-cycle pulse when I/Q update with a new symbol.
- busy  out  1  high while a partial symbol is held (bit count != 0).
- sym_cnt  out  CNT_W  symbols emitted since reset; present only with QAM_SYM_CNT_EN.

Behaviour:
- Reset (reset=0, asynchronous): I=0, Q=0, sym_valid=0, busy=0, bit count=0, shift register=0, latched mode=QPSK, sym_cnt=0.
- Bit accept: on an edge with en=1 and bit_valid=1, shift bit_in into the shift register (first bit becomes MSB) and increment the bit count.
- Mode latch: mode is sampled on the edge accepting the first bit of a symbol (count=0).
  - Mode changes mid-symbol are ignored until the next symbol boundary.
- Symbol complete: the edge accepting bit N (N = 2 for QPSK, 4 for 16-QAM) does all of the following:
  - resets the count to 0;
  - on the following edge, I/Q take the mapped values and sym_valid=1 for exactly one cycle.
  - Latency: last bit accepted at edge k -> I/Q/sym_valid valid after edge k+1.
- Back-to-back symbols: bit_valid may be high every cycle; no bit is lost and sym_valid pulses once per symbol.
- Hold: I/Q hold the last symbol between updates; sym_valid=0 otherwise.
- QPSK map, bits (b1 first, b0 second), identical to existing mapper:
  - 00 -> (I,Q)=(-3,+3); 01 -> (+3,+3); 11 -> (+3,-3); 10 -> (-3,-3).
- 16-QAM map, bits b3 b2 b1 b0 in arrival order:
  - I from (b3,b2), Q from (b1,b0).
  - Gray levels per pair: 00->-3, 01->-1, 11->+1, 10->+3.
- flush=1: count cleared and partial bits discarded that edge; I/Q unchanged; sym_valid=0.
  - If flush coincides with a bit accept, flush wins and the bit is discarded.
- en=0: partial symbol dropped, count=0, I/Q forced to 0 on the next edge, sym_valid=0, bit_valid ignored.
  - Re-enable starts a fresh symbol.
- busy = (count != 0), registered.
- Reset asserted mid-symbol: all state returns to reset values immediately; no sym_valid is generated for the partial symbol.

Optional Feature:
- Macro: QAM_SYM_CNT_EN.
- Defined: sym_cnt port exists; increments by 1 on every sym_valid pulse and wraps from 2^CNT_W-1 to 0; cleared by reset only (not by en or flush).
- Undefined: sym_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- QPSK map: en=1, mode=0, bits 0,1 on consecutive cycles -> one cycle after the second bit, I=+3, Q=+3, sym_valid=1 for 1 cycle.
  - Bits 1,0 -> (-3,-3).
- 16-QAM map: mode=1, bits 1,0,0,1 -> I=+3, Q=-1.
  - Bits 0,0,1,1 -> I=-3, Q=+1.
  - Sweep all 16 codes against the Gray table.
- Back-to-back: bit_valid held high, mode=0, stream 00 01 11 10 -> sym_valid every 2nd cycle, I/Q sequence (-3,+3),(+3,+3),(+3,-3),(-3,-3).
- Mid-symbol mode change: mode=1, send 1 bit, switch mode=0, send 3 more bits -> one 16-QAM symbol emitted; the next symbol is QPSK.
- Flush/en/reset: send 1 bit, then pulse flush -> busy=0, no sym_valid; next 2 QPSK bits produce a correct symbol.
  - en=0 -> I=Q=0 next cycle.
  - Assert reset after 3 of 4 bits -> all outputs 0 immediately.
- QAM_SYM_CNT_EN with CNT_W=4: emit 17 symbols -> sym_cnt reads 1 (wrap verified); flush and en do not clear it.
